adc_spi_control: RTL and testbench
==================================

Name: adc_spi_control

Overview:
- SPI master for an 8-channel, 12-bit serial ADC with an ADC128S022-style frame.
- Each frame is 16 SCLK cycles. The block sends a 3-bit channel address on DIN and receives a 12-bit sample on DOUT.
- It sits between the ADC pins and the demodulator datapath, and presents each sample with a one-clock valid strobe.
- The behavioural ADC bench model (adc_model) is a verification companion only. It is not part of this block.

Parameters:
- SCLK_HALF, 8, number of iCLK cycles per SCLK half-period (minimum 1). At 50 MHz this gives SCLK = 3.125 MHz.

Ports:
- iCLK  in  1  system clock; all logic is on the rising edge.
- iRST  in  1  synchronous reset, active-high.
- iGO  in  1  level enable; frames run back-to-back while high.
- iDOUT  in  1  ADC serial data out.
- iCH  in  3  channel address for the next frame.
- odata  out  12  last received sample.
- oDIN  out  1  serial address to the ADC.
- oCS_n  out  1  ADC chip select, active-low.
- oSCLK  out  1  ADC serial clock; idles high.
- en_data  out  1  one-iCLK pulse when odata updates.

Behaviour:
- Reset values (iRST=1 at a clock edge):
  - oCS_n=1, oSCLK=1, oDIN=0, odata=0, en_data=0.
  - State goes to IDLE; all counters clear.
  - Reset mid-frame aborts the frame with no en_data pulse.
- States: IDLE -> SETUP -> SHIFT -> QUIET -> IDLE.
- IDLE:
  - oCS_n=1, oSCLK=1.
  - If iGO=1, latch iCH into ch_r, drive oCS_n=0 and go to SETUP.
- SETUP:
  - Lasts SCLK_HALF clocks with oSCLK=1 (CS-to-first-falling-edge setup).
- SHIFT: 16 bit periods, n=0..15. Each period is SCLK low for SCLK_HALF clocks, then high for SCLK_HALF clocks.
  - oDIN update: at the start of the low phase, on the same edge that drives oSCLK low.
    - n=2 -> ch_r[2], n=3 -> ch_r[1], n=4 -> ch_r[0].
    - All other n -> 0.
  - iDOUT capture: on the iCLK edge that drives oSCLK high, shift iDOUT into a 16-bit shift register (MSB first).
  - Bits n=0..3 are leading zeros and are discarded. Bits n=4..15 form the sample, MSB first.
- End of frame:
  - On the 16th rising SCLK edge, odata <= shift register bits [11:0] including the bit just captured, and en_data=1 for exactly that one iCLK.
  - After the 16th high phase completes, oCS_n=1 and the state goes to QUIET.
- QUIET:
  - oCS_n=1, oSCLK=1 for 2*SCLK_HALF clocks, then IDLE.
  - If iGO is still 1 there, the next frame starts.
- Frame timing:
  - Frame period with iGO held high = 35*SCLK_HALF + 1 clocks (IDLE costs one clock).
  - en_data therefore repeats every 281 clocks at the default SCLK_HALF.
- Control and data rules:
  - iGO dropping mid-frame does not abort; the frame completes.
  - iCH changes mid-frame are ignored; ch_r is latched only in IDLE.
  - The ADC returns the channel addressed in the previous frame. The first frame after reset returns channel 0.
  - odata holds its value between strobes. No arithmetic is performed; the data is passed through unsigned.

Test Plan:
- Reset then idle:
  - Stimulus: iRST=1 for 3 clocks, then iGO=0 for 500 clocks.
  - Required: oCS_n=1, oSCLK=1, odata=0 and en_data=0 throughout.
- Single frame protocol (SCLK_HALF=8, iGO=1, iCH=3'b101):
  - oCS_n falls 1 clock after iGO is seen.
  - The first oSCLK fall comes 8 clocks later.
  - Exactly 16 SCLK pulses with a 16-clock period.
  - oDIN = 0,0,1,0,1,0… on falling edges n=0..5.
  - oCS_n rises 8 clocks after the 16th rising edge.
- Data capture:
  - The model returns 12'h000+(prev_ch<<8)+12'h0A5 with 4 leading zeros. With iCH=3 held, the 2nd frame gives odata=12'h3A5.
  - en_data pulses exactly one clock per frame, 281 clocks apart.
- Channel pipeline:
  - Stimulus: iCH=2 for frame 1, then iCH=7 from frame 2.
  - Required odata sequence: 12'h0A5 (channel 0, first frame), 12'h2A5, 12'h7A5.
- iGO drop mid-frame:
  - Stimulus: deassert iGO at SCLK pulse 6.
  - Required: the frame completes, en_data pulses once, and no new frame starts.
- Reset mid-frame:
  - Stimulus: iRST=1 at SCLK pulse 10.
  - Required: next clock oCS_n=1, oSCLK=1, odata=0, and no en_data pulse. After release with iGO=1 a clean frame follows.

Source files
------------

// File: rtl/adc_spi_control_if.sv
// Pin and datapath bundle for the serial ADC controller.
// The master modport is the controller side; slave is the ADC/datapath side.
interface adc_spi_control_if;
  logic        iGO;
  logic        iDOUT;
  logic [2:0]  iCH;
  logic [11:0] odata;
  logic        oDIN;
  logic        oCS_n;
  logic        oSCLK;
  logic        en_data;

  modport master (
    input  iGO, iDOUT, iCH,
    output odata, oDIN, oCS_n, oSCLK, en_data
  );

  modport slave (
    output iGO, iDOUT, iCH,
    input  odata, oDIN, oCS_n, oSCLK, en_data
  );
endinterface

// File: rtl/adc_spi_control.sv
// SPI master for an 8-channel 12-bit ADC (16-SCLK frame): sends a 3-bit channel
// address on DIN and returns each 12-bit sample with a one-clock valid strobe.
module adc_spi_control #(
  parameter int SCLK_HALF = 8
) (
  input logic              iCLK,
  input logic              iRST,
  adc_spi_control_if.master bus
);

  localparam int CW = $clog2(2 * SCLK_HALF + 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(SCLK_HALF - 1);
  localparam logic [CW-1:0] QUIET_LAST = CW'(2 * SCLK_HALF - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, QUIET} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_n;
  logic          phase_hi;
  logic [15:0]   shift_r;
  logic [2:0]    ch_r;
  logic          cs_n_r;
  logic          sclk_r;
  logic          din_r;
  logic [11:0]   data_r;
  logic          en_r;

  // Address bits ride in periods 2..4, MSB first; every other period sends zero.
  function automatic logic din_bit(input logic [3:0] n, input logic [2:0] ch);
    case (n)
      4'd2:    return ch[2];
      4'd3:    return ch[1];
      4'd4:    return ch[0];
      default: return 1'b0;
    endcase
  endfunction

  // NOTE: all state and outputs are registers updated with non-blocking
  // assignments, so every branch reads the pre-edge values consistently.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_n    <= '0;
      phase_hi <= 1'b0;
      shift_r  <= '0;
      ch_r     <= '0;
      cs_n_r   <= 1'b1;
      sclk_r   <= 1'b1;
      din_r    <= 1'b0;
      data_r   <= '0;
      en_r     <= 1'b0;
    end else begin
      // NOTE: default-low each clock makes en_data a single-cycle strobe.
      en_r <= 1'b0;
      unique case (state)
        IDLE: begin
          cs_n_r   <= 1'b1;
          sclk_r   <= 1'b1;
          din_r    <= 1'b0;
          cnt      <= '0;
          bit_n    <= '0;
          phase_hi <= 1'b0;
          if (bus.iGO) begin
            ch_r   <= bus.iCH;
            cs_n_r <= 1'b0;
            state  <= SETUP;
          end
        end

        SETUP: begin
          if (cnt == HALF_LAST) begin
            cnt    <= '0;
            sclk_r <= 1'b0;
            din_r  <= din_bit(4'd0, ch_r);
            state  <= SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        SHIFT: begin
          if (cnt != HALF_LAST) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (!phase_hi) begin
              // Rising SCLK edge: the ADC bit has been stable for a half period.
              sclk_r   <= 1'b1;
              phase_hi <= 1'b1;
              shift_r  <= {shift_r[14:0], bus.iDOUT};
              if (bit_n == 4'd15) begin
                data_r <= {shift_r[10:0], bus.iDOUT};
                en_r   <= 1'b1;
              end
            end else begin
              phase_hi <= 1'b0;
              if (bit_n == 4'd15) begin
                cs_n_r <= 1'b1;
                din_r  <= 1'b0;
                state  <= QUIET;
              end else begin
                bit_n  <= bit_n + 4'd1;
                sclk_r <= 1'b0;
                din_r  <= din_bit(bit_n + 4'd1, ch_r);
              end
            end
          end
        end

        QUIET: begin
          if (cnt == QUIET_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.oCS_n   = cs_n_r;
  assign bus.oSCLK   = sclk_r;
  assign bus.oDIN    = din_r;
  assign bus.odata   = data_r;
  assign bus.en_data = en_r;

endmodule

// File: tb/tb_adc_spi_control.sv
// Bench for adc_spi_control: behavioural ADC model, scoreboard of expected
// samples pushed at frame start, table-driven channel pipeline, corner sequences.
module tb_adc_spi_control;

  localparam int HALF  = 8;
  localparam int FRAME = 35 * HALF + 1;

  logic clk;
  logic rst;

  adc_spi_control_if bus ();

  adc_spi_control #(.SCLK_HALF(HALF)) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ADC model: address sampled on rising SCLK (periods 2..4), data shifted out
  // on falling SCLK; returns the channel addressed by the last complete frame.
  logic        dout_v   = 1'b0;
  logic        m_cs_q   = 1'b1;
  logic        m_sclk_q = 1'b1;
  logic [2:0]  m_prev_ch = 3'd0;
  logic [2:0]  m_addr    = 3'd0;
  logic [15:0] m_frame   = 16'h0;
  int          m_rise    = 0;
  int          m_fall    = 0;

  assign bus.iDOUT = dout_v;

  always @(negedge clk) begin
    if (rst) begin
      m_prev_ch = 3'd0;
      m_rise    = 0;
      m_fall    = 0;
    end else begin
      if (m_cs_q && !bus.oCS_n) begin
        m_frame = {5'b0, m_prev_ch, 8'hA5};
        m_rise  = 0;
        m_fall  = 0;
        m_addr  = 3'd0;
      end
      if (!bus.oCS_n && m_sclk_q && !bus.oSCLK) begin
        if (m_fall < 16) dout_v = m_frame[15 - m_fall];
        m_fall++;
      end
      if (!bus.oCS_n && !m_sclk_q && bus.oSCLK) begin
        if (m_rise >= 2 && m_rise <= 4) m_addr = {m_addr[1:0], bus.oDIN};
        m_rise++;
      end
      if (!m_cs_q && bus.oCS_n && m_rise == 16) m_prev_ch = m_addr;
    end
    m_cs_q   = bus.oCS_n;
    m_sclk_q = bus.oSCLK;
  end

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [11:0] sb[$];
  logic [2:0]  sb_prev_ch = 3'd0;
  logic        sb_cs_q = 1'b1;
  logic        sb_en_q = 1'b0;
  int          last_en_cyc = 0;
  int          en_gap = 0;

  typedef enum {S_CS, S_SCLK, S_EN} sig_e;

  typedef struct {
    logic [2:0]  ch;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // One clock, sampled on the falling edge; also runs the scoreboard.
  task automatic tick();
    logic [11:0] e;
    @(negedge clk);
    cyc++;
    if (rst) begin
      sb.delete();
      sb_prev_ch = 3'd0;
    end else begin
      if (sb_cs_q && !bus.oCS_n) begin
        sb.push_back({1'b0, sb_prev_ch, 8'hA5});
        sb_prev_ch = bus.iCH;
      end
      if (bus.en_data === 1'b1) begin
        check("en_width", {31'b0, sb_en_q}, 0);
        en_gap      = cyc - last_en_cyc;
        last_en_cyc = cyc;
        if (sb.size() == 0) begin
          check("sb_unexpected_strobe", 1, 0);
        end else begin
          e = sb.pop_front();
          check("sb_odata", {20'b0, bus.odata}, {20'b0, e});
        end
      end
    end
    sb_cs_q = bus.oCS_n;
    sb_en_q = bus.en_data;
  endtask

  function automatic logic sig_val(input sig_e s);
    case (s)
      S_CS:    return bus.oCS_n;
      S_SCLK:  return bus.oSCLK;
      default: return bus.en_data;
    endcase
  endfunction

  task automatic wait_sig(input sig_e s, input logic level, input string name);
    int n;
    n = 0;
    while (sig_val(s) !== level && n < 2 * FRAME) begin
      tick();
      n++;
    end
    if (sig_val(s) !== level) check({name, "_timeout"}, 1, 0);
  endtask

  task automatic count_falls(input int target, input string name);
    int   n;
    int   falls;
    logic prev;
    n     = 0;
    falls = 0;
    prev  = bus.oSCLK;
    while (falls < target && n < 2 * FRAME) begin
      tick();
      n++;
      if (prev && !bus.oSCLK) falls++;
      prev = bus.oSCLK;
    end
    if (falls < target) check({name, "_timeout"}, 1, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    logic din_exp[6];
    int   fall_t[16];
    logic din_at[16];
    int   t_cs, t_r16, t_csr, falls, rises, n, bad, en_cnt, cs_falls;
    logic prev_s, prev_c, en_at_r16;

    din_exp = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[0] = '{3'd2, 12'h0A5};
    vecs[1] = '{3'd7, 12'h2A5};
    vecs[2] = '{3'd7, 12'h7A5};
    vecs[3] = '{3'd3, 12'h7A5};
    vecs[4] = '{3'd5, 12'h3A5};
    vecs[5] = '{3'd0, 12'h5A5};
    vecs[6] = '{3'd1, 12'h0A5};
    vecs[7] = '{3'd4, 12'h1A5};

    // Reset values, then a long idle with iGO low.
    rst    = 1'b1;
    bus.iGO = 1'b0;
    bus.iCH = 3'd0;
    repeat (3) tick();
    check("rst_cs_n",  {31'b0, bus.oCS_n},   1);
    check("rst_sclk",  {31'b0, bus.oSCLK},   1);
    check("rst_din",   {31'b0, bus.oDIN},    0);
    check("rst_odata", {20'b0, bus.odata},   0);
    check("rst_en",    {31'b0, bus.en_data}, 0);
    rst = 1'b0;
    bad = 0;
    repeat (500) begin
      tick();
      if (bus.oCS_n !== 1'b1 || bus.oSCLK !== 1'b1 || bus.odata !== 12'h0 || bus.en_data !== 1'b0)
        bad++;
    end
    check("idle_bad_cycles", bad, 0);

    // Single frame protocol, iCH=5.
    do_reset();
    bus.iCH = 3'b101;
    bus.iGO = 1'b1;
    tick();
    check("cs_fall_latency", {31'b0, bus.oCS_n}, 0);
    bus.iGO   = 1'b0;
    t_cs      = cyc;
    t_r16     = 0;
    t_csr     = 0;
    falls     = 0;
    rises     = 0;
    en_at_r16 = 1'b0;
    prev_s    = bus.oSCLK;
    n         = 0;
    while (bus.oCS_n !== 1'b1 && n < 2 * FRAME) begin
      tick();
      n++;
      if (prev_s && !bus.oSCLK) begin
        if (falls < 16) begin
          fall_t[falls] = cyc;
          din_at[falls] = bus.oDIN;
        end
        falls++;
      end
      if (!prev_s && bus.oSCLK) begin
        rises++;
        if (rises == 16) begin
          t_r16     = cyc;
          en_at_r16 = bus.en_data;
        end
      end
      prev_s = bus.oSCLK;
    end
    t_csr = cyc;
    if (bus.oCS_n !== 1'b1) check("frame_end_timeout", 1, 0);
    check("sclk_rises", rises, 16);
    check("sclk_falls", falls, 16);
    if (falls >= 16) begin
      check("first_fall_delay", fall_t[0] - t_cs, HALF);
      bad = 0;
      for (int i = 1; i < 16; i++) if (fall_t[i] - fall_t[i-1] != 2 * HALF) bad++;
      check("sclk_period_bad", bad, 0);
      for (int i = 0; i < 6; i++) check($sformatf("din_n%0d", i), {31'b0, din_at[i]}, {31'b0, din_exp[i]});
    end
    check("cs_rise_after_r16", t_csr - t_r16, HALF);
    check("en_at_r16", {31'b0, en_at_r16}, 1);
    repeat (3 * HALF) tick();

    // Data capture: iCH=3 held, second frame returns channel 3.
    do_reset();
    bus.iCH = 3'd3;
    bus.iGO = 1'b1;
    wait_sig(S_EN, 1'b1, "cap_en1");
    check("cap_odata1", {20'b0, bus.odata}, 12'h0A5);
    tick();
    wait_sig(S_EN, 1'b1, "cap_en2");
    check("cap_odata2", {20'b0, bus.odata}, 12'h3A5);
    check("cap_en_gap", en_gap, FRAME);
    bus.iGO = 1'b0;
    repeat (4 * HALF) tick();

    // Channel pipeline table; iCH changes right after each CS fall (ignored mid-frame).
    do_reset();
    bus.iCH = vecs[0].ch;
    bus.iGO = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_sig(S_CS, 1'b1, "pipe_cs_high");
      wait_sig(S_CS, 1'b0, "pipe_cs_low");
      if (i < 7) bus.iCH = vecs[i+1].ch;
      wait_sig(S_EN, 1'b1, "pipe_en");
      check($sformatf("pipe_odata_%0d", i), {20'b0, bus.odata}, {20'b0, vecs[i].exp});
      if (i > 0) check($sformatf("pipe_gap_%0d", i), en_gap, FRAME);
      if (i == 7) bus.iGO = 1'b0;
      tick();
    end
    repeat (4 * HALF) tick();

    // iGO dropped at SCLK pulse 6: frame completes, nothing follows.
    do_reset();
    bus.iCH = 3'd1;
    bus.iGO = 1'b1;
    count_falls(6, "drop_falls");
    bus.iGO  = 1'b0;
    en_cnt   = 0;
    cs_falls = 0;
    prev_c   = bus.oCS_n;
    repeat (3 * FRAME) begin
      tick();
      if (bus.en_data === 1'b1) en_cnt++;
      if (prev_c && !bus.oCS_n) cs_falls++;
      prev_c = bus.oCS_n;
    end
    check("drop_en_count", en_cnt, 1);
    check("drop_cs_falls", cs_falls, 0);
    check("drop_idle_cs", {31'b0, bus.oCS_n}, 1);
    check("drop_odata", {20'b0, bus.odata}, 12'h0A5);

    // Reset at SCLK pulse 10 of the second frame, then a clean frame.
    do_reset();
    bus.iCH = 3'd6;
    bus.iGO = 1'b1;
    wait_sig(S_EN, 1'b1, "mrst_en1");
    tick();
    count_falls(10, "mrst_falls");
    rst = 1'b1;
    tick();
    check("mrst_cs_n",  {31'b0, bus.oCS_n},   1);
    check("mrst_sclk",  {31'b0, bus.oSCLK},   1);
    check("mrst_odata", {20'b0, bus.odata},   0);
    check("mrst_en",    {31'b0, bus.en_data}, 0);
    en_cnt = 0;
    repeat (3) begin
      tick();
      if (bus.en_data !== 1'b0) en_cnt++;
    end
    check("mrst_en_during_rst", en_cnt, 0);
    rst = 1'b0;
    wait_sig(S_EN, 1'b1, "mrst_en2");
    check("mrst_clean_odata", {20'b0, bus.odata}, 12'h0A5);
    bus.iGO = 1'b0;
    repeat (4 * HALF) tick();

    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
